fadd_pipe: RTL and testbench
============================

Name: fadd_pipe

Overview:
- Parametrised, fully pipelined IEEE-754 binary floating-point adder/subtractor.
- Successor to the single-precision multi-cycle adder.
- Generic exponent/mantissa widths, explicit add/sub operation, one issue per cycle, fixed latency with a result-valid strobe, and optional dynamic rounding modes.
- Sits in the FP execution unit beside the multiplier; the issue logic drives req and consumes ack.

Parameters:
- EXP_W, 8: exponent field width (5 gives binary16, 11 gives binary64).
- MAN_W, 23: stored fraction width (10 gives binary16, 52 gives binary64).
- W = 1+EXP_W+MAN_W: derived operand width. Not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  operand valid; sampled every cycle, no backpressure.
- sub  in  1  0: x+y; 1: x-y (y sign inverted before the effective operation).
- rm  in  3  rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM; 5-7 are treated as RNE.
- x  in  W  operand A.
- y  in  W  operand B.
- ack  out  1  result valid, exactly one cycle per accepted req.
- rslt  out  W  result.
- flag  out  5  {NV, DZ, OF, UF, NX}. DZ is always 0.

Behaviour:
- Reset: ack=0, rslt=0, flag=0, all stage valid bits cleared. Reset mid-operation discards every in-flight op; no ack is produced for those ops.
- Pipeline is 3 registered stages. req in cycle N gives ack in cycle N+3. Back-to-back reqs give back-to-back acks in order.
- While ack=0, rslt and flag hold their last values.
- Stage 1 (unpack/swap/align):
  - Decode class: zero, subnormal, normal, inf, qNaN, sNaN.
  - Subnormal effective exponent is 1 with hidden bit 0.
  - Larger-magnitude operand goes to the big path; compare {exp, frac}.
  - Align shift = exponent difference, saturated at MAN_W+4.
  - Guard/round/sticky retained. Sticky is the OR of all bits shifted out.
- Stage 2 (add/sub):
  - Effective subtract = sx ^ sy ^ sub.
  - MAN_W+5-bit magnitude add or subtract; carry-out retained.
  - Result sign = big operand sign.
- Stage 3 (normalise/round/special):
  - Leading-zero count with left shift, limited so the exponent does not drop below 1; this yields a subnormal output.
  - Carry-out gives a right shift by 1 with sticky folded in.
  - Round per mode using G/R/S and LSB. Mantissa rounding carry increments the exponent.
- Special-case priority:
  - Any sNaN, or inf minus inf under effective subtraction: rslt = {1, all-ones exp, 1, zeros}, NV=1.
  - Otherwise, a qNaN input propagates quieted (x first, then y), NV=0.
  - Any inf: rslt = that inf, with sign adjusted by sub for y.
  - Exact zero sum: sign is +0, except −0 when rm=RDN. Sign is preserved when both inputs are zeros of equal effective sign.
- Overflow (rounded exponent ≥ all-ones): OF=1, NX=1. Result is inf for RNE/RMM and for the directed mode toward the result's sign; otherwise max finite.
- UF=1 iff the result is tiny before rounding AND inexact.
- NX=1 iff any discarded bit is nonzero, or overflow occurred.

Optional Feature:
- Macro FADD_RM_EN.
- Defined: rm input honoured as specified above.
- Undefined: rm is ignored and rounding is hardwired to RNE. The RDN zero-sign rule does not apply; exact zero is +0 except when both inputs are equal-sign zeros. The port stays present for interface compatibility.

Test Plan:
- Default parameters, req with x=0x3F800000, y=0x3F800000, sub=0 -> ack 3 cycles later, rslt=0x40000000, flag=0x00.
- x=0x7F800000, y=0x7F800000, sub=1 -> rslt=0xFFC00000, flag=0x10. Then x=0x7F7FFFFF + y=0x7F7FFFFF -> rslt=0x7F800000, flag=0x05.
- Subnormal and cancellation cases:
  - 0x00000001 + 0x00000001 -> rslt=0x00000002, flag=0x00.
  - 0x3F800001 - 0x3F800000 -> rslt=0x34000000, flag=0x00.
- Tie rounding: 0x3F800000 + 0x33800000 with rm=0 -> rslt=0x3F800000, flag=0x01. With FADD_RM_EN and rm=3 -> rslt=0x3F800001, flag=0x01.
- Pipeline stress: 8 consecutive reqs with reset asserted in the 4th cycle.
  - Reqs accepted before reset: no ack.
  - ack, rslt and flag read 0 the cycle after reset.
  - Reqs after reset deassertion each produce an ack 3 cycles later, in order.
- EXP_W=5, MAN_W=10: 0x3C00 + 0x3C00 -> rslt=0x4000, and 0x7BFF + 0x7BFF -> rslt=0x7C00, flag=0x05.

Source files
------------

// File: rtl/fadd_pipe.sv
// fadd_pipe: three-stage pipelined IEEE-754 binary floating-point adder/subtractor.
// Stage 1 unpacks, classifies, swaps and aligns; stage 2 adds or subtracts the
// magnitudes; stage 3 normalises, rounds and merges special cases into the output.
// Optional macro FADD_RM_EN: when defined the rm input selects the rounding mode,
// otherwise rounding is fixed to round-to-nearest-even and rm is ignored.
module fadd_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req,
    input  logic         sub,
    input  logic [2:0]   rm,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic         ack,
    output logic [W-1:0] rslt,
    output logic [4:0]   flag
);
    // MW: {hidden, fraction, G, R, S}; SW adds the carry-out bit above it
    localparam int MW  = MAN_W + 4;
    localparam int SW  = MAN_W + 5;
    localparam int EW  = EXP_W + 2;
    localparam int MRW = MAN_W + 2;
    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;
    localparam logic [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);

    logic [2:0] rm_n;
`ifdef FADD_RM_EN
    assign rm_n = (rm > RM_RMM) ? RM_RNE : rm;
`else
    logic unused_rm;
    assign unused_rm = ^rm;
    assign rm_n = RM_RNE;
`endif

    // ---------------- stage 1: unpack / swap / align ----------------
    logic             sx, sy, s_big, s_sml, x_big;
    logic [EXP_W-1:0] ex, ey, eex, eey, e_big, e_sml, d;
    logic [MAN_W-1:0] fx, fy;
    logic             nan_x, nan_y, snan_x, snan_y, inf_x, inf_y, invalid, special;
    logic [MAN_W:0]   m_big, m_sml;
    logic [2*MW-1:0]  wide;
    logic [31:0]      dsat;
    logic [W-1:0]     spec_r;

    // classify operands, pick the larger magnitude and align the smaller one
    always_comb begin
        sx     = x[W-1];
        ex     = x[W-2:MAN_W];
        fx     = x[MAN_W-1:0];
        sy     = y[W-1] ^ sub;
        ey     = y[W-2:MAN_W];
        fy     = y[MAN_W-1:0];
        nan_x  = (&ex) & (|fx);
        nan_y  = (&ey) & (|fy);
        snan_x = nan_x & ~fx[MAN_W-1];
        snan_y = nan_y & ~fy[MAN_W-1];
        inf_x  = (&ex) & ~(|fx);
        inf_y  = (&ey) & ~(|fy);
        eex    = (|ex) ? ex : EXP_W'(1);
        eey    = (|ey) ? ey : EXP_W'(1);
        x_big  = {ex, fx} >= {ey, fy};
        if (x_big) begin
            e_big = eex; e_sml = eey; s_big = sx; s_sml = sy;
            m_big = {|ex, fx}; m_sml = {|ey, fy};
        end else begin
            e_big = eey; e_sml = eex; s_big = sy; s_sml = sx;
            m_big = {|ey, fy}; m_sml = {|ex, fx};
        end
        d    = e_big - e_sml;
        dsat = (32'(d) > 32'(MW)) ? 32'(MW) : 32'(d);
        // bits falling into the lower half are the shifted-out ones
        wide = {m_sml, 3'b000, {MW{1'b0}}} >> dsat;

        invalid = snan_x | snan_y | (inf_x & inf_y & (sx ^ sy));
        special = invalid | nan_x | nan_y | inf_x | inf_y;
        if (invalid)
            spec_r = {1'b1, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        else if (nan_x)
            spec_r = {sx, ex, 1'b1, fx[MAN_W-2:0]};
        else if (nan_y)
            spec_r = {y[W-1], ey, 1'b1, fy[MAN_W-2:0]};
        else if (inf_x)
            spec_r = x;
        else
            spec_r = {sy, ey, fy};
    end

    logic             v1, spec1, nv1, sb1, ss1;
    logic [W-1:0]     sr1;
    logic [EXP_W-1:0] e1;
    logic [MW-1:0]    mb1, ms1;
    logic [2:0]       rm1;

    // stage 1 register; only the valid bit is reset
    always_ff @(posedge clk) begin
        if (reset) v1 <= 1'b0;
        else       v1 <= req;
        spec1 <= special;
        nv1   <= invalid;
        sr1   <= spec_r;
        sb1   <= s_big;
        ss1   <= s_sml;
        e1    <= e_big;
        mb1   <= {m_big, 3'b000};
        ms1   <= {wide[2*MW-1:MW+1], wide[MW] | (|wide[MW-1:0])};
        rm1   <= rm_n;
    end

    // ---------------- stage 2: magnitude add / subtract ----------------
    logic          eff_sub, sgn_s2;
    logic [SW-1:0] sum;

    // effective operation, signed-zero rule for an exact zero sum
    always_comb begin
        eff_sub = sb1 ^ ss1;
        sum     = eff_sub ? ({1'b0, mb1} - {1'b0, ms1}) : ({1'b0, mb1} + {1'b0, ms1});
        sgn_s2  = sb1;
        if (sum == '0)
            sgn_s2 = eff_sub ? (rm1 == RM_RDN) : sb1;
    end

    logic             v2, spec2, nv2, sg2, zero2;
    logic [W-1:0]     sr2;
    logic [EXP_W-1:0] e2;
    logic [SW-1:0]    sum2;
    logic [2:0]       rm2;

    // stage 2 register
    always_ff @(posedge clk) begin
        if (reset) v2 <= 1'b0;
        else       v2 <= v1;
        spec2 <= spec1;
        nv2   <= nv1;
        sr2   <= sr1;
        sg2   <= sgn_s2;
        zero2 <= (sum == '0);
        e2    <= e1;
        sum2  <= sum;
        rm2   <= rm1;
    end

    // ---------------- stage 3: normalise / round / special ----------------
    logic [EW-1:0]    e_w, en, ef;
    logic [31:0]      lz, lim, shamt;
    logic [MW-1:0]    m;
    logic [MRW-1:0]   mr;
    logic [MAN_W-1:0] fr;
    logic             tiny, inexact, inc, ovf, to_inf;
    logic [W-1:0]     r3;
    logic [4:0]       f3;

    // normalise (left shift stops at exponent 1), round, then pick the result
    always_comb begin
        e_w = {2'b00, e2};
        lz  = 32'(MW);
        for (int i = 0; i < MW; i++)
            if (sum2[i]) lz = 32'(MW - 1 - i);
        lim   = 32'(e_w) - 32'd1;
        shamt = (lz < lim) ? lz : lim;
        if (sum2[SW-1]) begin
            m  = {sum2[SW-1:2], sum2[1] | sum2[0]};
            en = e_w + EW'(1);
        end else begin
            m  = sum2[MW-1:0] << shamt;
            en = e_w - EW'(shamt);
        end
        tiny    = ~m[MW-1];
        inexact = |m[2:0];
        case (rm2)
            RM_RNE:  inc = m[2] & (m[1] | m[0] | m[3]);
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sg2 & inexact;
            RM_RUP:  inc = ~sg2 & inexact;
            RM_RMM:  inc = m[2];
            default: inc = m[2] & (m[1] | m[0] | m[3]);
        endcase
        mr = {1'b0, m[MW-1:3]} + MRW'(inc);
        if (mr[MAN_W+1]) begin
            ef = en + EW'(1);
            fr = mr[MAN_W:1];
        end else begin
            ef = mr[MAN_W] ? en : '0;
            fr = mr[MAN_W-1:0];
        end
        ovf    = ef >= EXP_MAX;
        to_inf = (rm2 == RM_RNE) || (rm2 == RM_RMM) ||
                 ((rm2 == RM_RDN) && sg2) || ((rm2 == RM_RUP) && !sg2);

        r3 = {sg2, ef[EXP_W-1:0], fr};
        f3 = {3'b000, tiny & inexact, inexact};
        if (spec2) begin
            r3 = sr2;
            f3 = {nv2, 4'b0000};
        end else if (zero2) begin
            r3 = {sg2, {(W-1){1'b0}}};
            f3 = 5'b00000;
        end else if (ovf) begin
            r3 = to_inf ? {sg2, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                        : {sg2, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
            f3 = 5'b00101;
        end
    end

    // output register; result and flags hold while no op completes
    always_ff @(posedge clk) begin
        if (reset) begin
            ack  <= 1'b0;
            rslt <= '0;
            flag <= '0;
        end else begin
            ack <= v2;
            if (v2) begin
                rslt <= r3;
                flag <= f3;
            end
        end
    end

endmodule

// File: tb/tb_fadd_pipe.sv
// Directed testbench for fadd_pipe: binary32 instance plus a binary16 instance.
// Expectations for rounding-mode cases follow the FADD_RM_EN build setting.
module tb_fadd_pipe;
    logic        clk = 1'b0;
    logic        reset;
    logic        req, sub;
    logic [2:0]  rm;
    logic [31:0] x, y, rslt;
    logic        ack;
    logic [4:0]  flag;
    logic        req_h, sub_h;
    logic [2:0]  rm_h;
    logic [15:0] x_h, y_h, rslt_h;
    logic        ack_h;
    logic [4:0]  flag_h;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fadd_pipe u_dut (
        .clk(clk), .reset(reset), .req(req), .sub(sub), .rm(rm),
        .x(x), .y(y), .ack(ack), .rslt(rslt), .flag(flag)
    );

    fadd_pipe #(.EXP_W(5), .MAN_W(10)) u_h (
        .clk(clk), .reset(reset), .req(req_h), .sub(sub_h), .rm(rm_h),
        .x(x_h), .y(y_h), .ack(ack_h), .rslt(rslt_h), .flag(flag_h)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic run32(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [2:0] m,
                         input logic [31:0] er, input logic [4:0] efl);
        @(negedge clk);
        req = 1'b1; x = a; y = b; sub = s; rm = m;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        chk({tag, "_early"}, 64'(ack), 64'd0);
        @(negedge clk);
        chk({tag, "_ack"}, 64'(ack), 64'd1);
        chk({tag, "_rslt"}, 64'(rslt), 64'(er));
        chk({tag, "_flag"}, 64'(flag), 64'(efl));
    endtask

    task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] er, input logic [4:0] efl);
        @(negedge clk);
        req_h = 1'b1; x_h = a; y_h = b; sub_h = 1'b0; rm_h = 3'd0;
        @(negedge clk);
        req_h = 1'b0;
        @(negedge clk);
        chk({tag, "_early"}, 64'(ack_h), 64'd0);
        @(negedge clk);
        chk({tag, "_ack"}, 64'(ack_h), 64'd1);
        chk({tag, "_rslt"}, 64'(rslt_h), 64'(er));
        chk({tag, "_flag"}, 64'(flag_h), 64'(efl));
    endtask

    logic [31:0] st_x [8];
    logic [31:0] st_r [4];
    logic [31:0] rup_tie, rdn_zero, rtz_ovf;

    initial begin
        st_x = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        st_r = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
`ifdef FADD_RM_EN
        rup_tie  = 32'h3F800001;
        rdn_zero = 32'h80000000;
        rtz_ovf  = 32'h7F7FFFFF;
`else
        rup_tie  = 32'h3F800000;
        rdn_zero = 32'h00000000;
        rtz_ovf  = 32'h7F800000;
`endif
        reset = 1'b1; req = 1'b0; sub = 1'b0; rm = 3'd0; x = '0; y = '0;
        req_h = 1'b0; sub_h = 1'b0; rm_h = 3'd0; x_h = '0; y_h = '0;
        repeat (3) @(negedge clk);
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_rslt", 64'(rslt), 64'd0);
        chk("rst_flag", 64'(flag), 64'd0);
        chk("rst_ack_h", 64'(ack_h), 64'd0);
        reset = 1'b0;

        run32("one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0, 3'd0, 32'h40000000, 5'h00);
        run32("inf_minus_inf", 32'h7F800000, 32'h7F800000, 1'b1, 3'd0, 32'hFFC00000, 5'h10);
        run32("max_plus_max", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'd0, 32'h7F800000, 5'h05);
        run32("max_rtz", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'd1, rtz_ovf, 5'h05);
        run32("denorm_add", 32'h00000001, 32'h00000001, 1'b0, 3'd0, 32'h00000002, 5'h00);
        run32("cancel", 32'h3F800001, 32'h3F800000, 1'b1, 3'd0, 32'h34000000, 5'h00);
        run32("minnorm_sub", 32'h00800000, 32'h00000001, 1'b1, 3'd0, 32'h007FFFFF, 5'h00);
        run32("tie_rne", 32'h3F800000, 32'h33800000, 1'b0, 3'd0, 32'h3F800000, 5'h01);
        run32("tie_rup", 32'h3F800000, 32'h33800000, 1'b0, 3'd3, rup_tie, 5'h01);
        run32("tie_rm5", 32'h3F800000, 32'h33800000, 1'b0, 3'd5, 32'h3F800000, 5'h01);
        run32("round_carry", 32'h3FFFFFFF, 32'h33800000, 1'b0, 3'd0, 32'h40000000, 5'h01);
        run32("two_minus_one", 32'h40000000, 32'h3F800000, 1'b1, 3'd0, 32'h3F800000, 5'h00);
        run32("neg_mix", 32'hBF800000, 32'h3F000000, 1'b0, 3'd0, 32'hBF000000, 5'h00);
        run32("exact_zero", 32'h3F800000, 32'h3F800000, 1'b1, 3'd0, 32'h00000000, 5'h00);
        run32("zero_rdn", 32'h3F800000, 32'h3F800000, 1'b1, 3'd2, rdn_zero, 5'h00);
        run32("negzero_sum", 32'h80000000, 32'h80000000, 1'b0, 3'd0, 32'h80000000, 5'h00);
        run32("snan_in", 32'h3F800000, 32'h7F800001, 1'b0, 3'd0, 32'hFFC00000, 5'h10);
        run32("qnan_x", 32'h7FC12345, 32'h3F800000, 1'b0, 3'd0, 32'h7FC12345, 5'h00);
        run32("inf_plus_one", 32'h7F800000, 32'h3F800000, 1'b0, 3'd0, 32'h7F800000, 5'h00);
        run32("one_minus_inf", 32'h3F800000, 32'h7F800000, 1'b1, 3'd0, 32'hFF800000, 5'h00);

        run16("h_one_plus_one", 16'h3C00, 16'h3C00, 16'h4000, 5'h00);
        run16("h_max_plus_max", 16'h7BFF, 16'h7BFF, 16'h7C00, 5'h05);

        // eight back-to-back requests, reset asserted during the fourth
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 4) begin
                chk("st_rst_ack", 64'(ack), 64'd0);
                chk("st_rst_rslt", 64'(rslt), 64'd0);
                chk("st_rst_flag", 64'(flag), 64'd0);
            end
            if (i == 5 || i == 6) chk($sformatf("st_noack%0d", i), 64'(ack), 64'd0);
            if (i == 7) begin
                chk("st_ack0", 64'(ack), 64'd1);
                chk("st_rslt0", 64'(rslt), 64'(st_r[0]));
            end
            req = 1'b1; x = st_x[i]; y = 32'h3F800000; sub = 1'b0; rm = 3'd0;
            reset = (i == 3);
        end
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            req = 1'b0;
            chk($sformatf("st_ack%0d", k), 64'(ack), 64'd1);
            chk($sformatf("st_rslt%0d", k), 64'(rslt), 64'(st_r[k]));
        end
        @(negedge clk);
        chk("st_tail", 64'(ack), 64'd0);
        chk("st_hold", 64'(rslt), 64'(st_r[3]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
